chi_reset_sequencer: RTL and testbench
======================================

CHI_RESET_SEQUENCER -- requirements
Module: chi_reset_sequencer

Interface
REQ-001 Parameter NUM_RN, default 4, number of request nodes, legal 1..16.
REQ-002 Parameter NUM_SN, default 2, number of slave nodes, legal 1..16.
REQ-003 Parameter HOLD_CYC, default 16, reset-assert hold length in cycles, legal >=1.
REQ-004 Parameter GAP_CYC, default 4, spacing between staged releases in cycles, legal >=1.
REQ-005 Ports are as follows:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- seq_start  in  1  request to re-run the full reset sequence.
- rn_warm_req  in  NUM_RN  per-RN warm-reset request, level, held until ack.
- rn_warm_ack  out  NUM_RN  one-cycle pulse on completion of the warm reset.
- rn_resetn  out  NUM_RN  per-RN reset, active-low.
- sn_resetn  out  NUM_SN  per-SN reset, active-low.
- seq_busy  out  1  high whenever not in READY.
- seq_done  out  1  high in READY only.
REQ-006 The block has one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-007 All outputs are registered.

Function
REQ-008 The states are HOLD, GAP_SN, RN_REL, READY and WARM.
REQ-009 HOLD behaviour:
- all rn_resetn and sn_resetn are 0;
- count HOLD_CYC cycles;
- then set all sn_resetn to 1 simultaneously and go to GAP_SN.
REQ-010 GAP_SN: wait GAP_CYC cycles, then go to RN_REL with idx=0.
REQ-011 RN_REL behaviour:
- set rn_resetn[idx] to 1;
- wait GAP_CYC cycles;
- idx++;
- after idx=NUM_RN-1 completes its gap, go to READY.
REQ-012 Cycle-level timing, with cycle 0 being the first cycle in which rst=0:
- sn_resetn rises at cycle HOLD_CYC;
- rn_resetn[i] rises at cycle HOLD_CYC+(i+1)*GAP_CYC;
- seq_done rises at cycle HOLD_CYC+(NUM_RN+1)*GAP_CYC.
REQ-013 READY: seq_start=1 drives all resets to 0 on the next cycle and goes to HOLD; seq_start has priority over any rn_warm_req in the same cycle.
REQ-014 READY, no seq_start, any rn_warm_req set: grant one RN by round-robin starting from the pointer, then go to WARM.
REQ-015 WARM sequence for granted RN g:
- rn_resetn[g]=0 for HOLD_CYC cycles;
- then rn_resetn[g]=1 and rn_warm_ack[g]=1 for one cycle;
- pointer moves to g+1 mod NUM_RN;
- return to READY.
REQ-016 WARM leaves every other RN and every SN untouched.
REQ-017 Arbitration happens only in the cycle spent in READY, so back-to-back warm resets are spaced HOLD_CYC+1 cycles apart.
REQ-018 seq_start outside READY is ignored and not queued.
REQ-019 rn_warm_req outside READY is held pending by the requester, not by the block.
REQ-020 rn_warm_req still high in the cycle after its ack is treated as a new request.
REQ-021 Bits of rn_warm_req at index >= NUM_RN do not exist; the arbiter only considers legal indices.
REQ-022 The cycle counter is $clog2(max(HOLD_CYC,GAP_CYC)+1) bits wide, with no wrap-around within any phase.

Reset
REQ-023 While rst=1:
- state is HOLD, with counter, idx and round-robin pointer all 0;
- rn_resetn and sn_resetn are all 0;
- rn_warm_ack is 0, seq_busy is 1, seq_done is 0.
REQ-024 rst asserted in any state, including mid-WARM or mid-RN_REL, aborts the sequence; the next cycle obeys REQ-023, and no ack is issued for an aborted warm reset.

Structure
REQ-025 Package chi_reset_seq_pkg holds the state enum, the default parameter constants and the counter-width function.
REQ-026 Sub-module chi_reset_rr_arb implements the NUM_RN-wide round-robin grant with pointer update; all other logic is inline.

Verification
REQ-027 All scenarios use NUM_RN=4, NUM_SN=2, HOLD_CYC=16, GAP_CYC=4.
REQ-028 Power-on: rst high for 3 cycles, then low.
- sn_resetn=2'b11 at cycle 16.
- rn_resetn bits rise at cycles 20, 24, 28 and 32.
- seq_done=1 at cycle 36.
REQ-029 Single warm reset: rn_warm_req=4'b0100 in READY.
- rn_resetn[2]=0 for 16 cycles, then rn_warm_ack=4'b0100 for 1 cycle.
- rn_resetn[0,1,3] and sn_resetn stay 1 throughout.
REQ-030 Multiple warm resets: rn_warm_req=4'b1011 with pointer 0, each requester dropping its req on ack.
- Acks are issued in order RN0, RN1, RN3, each 17 cycles apart.
REQ-031 Collision: seq_start=1 and rn_warm_req=4'b0001 in the same READY cycle.
- The full sequence runs with REQ-028 timing, and no ack is issued during it.
REQ-032 Mid-sequence reset: rst pulsed at cycle 26.
- All outputs return to reset values on the next cycle.
- The sequence restarts, with timing counted from the first cycle after rst deasserts.
REQ-033 Start during warm: seq_start pulsed during WARM.
- The pulse is ignored; the warm reset completes and the block returns to READY with seq_done=1.

Source files
------------

// File: rtl/chi_reset_seq_pkg.sv
// Shared types and sizing helpers for the CHI reset sequencer and its arbiter.
package chi_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_GAP_SN = 3'd1,
    ST_RN_REL = 3'd2,
    ST_READY  = 3'd3,
    ST_WARM   = 3'd4
  } seq_state_e;

  localparam int DEF_NUM_RN   = 4;
  localparam int DEF_NUM_SN   = 2;
  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_GAP_CYC  = 4;

  // Wide enough to count up to the longer of the two phase lengths.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int m;
    m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chi_reset_rr_arb.sv
// Round-robin grant over the RN warm-reset requests; the pointer advances past
// the granted RN only once its warm reset has completed.
module chi_reset_rr_arb
  import chi_reset_seq_pkg::*;
#(
  parameter int NUM_RN = DEF_NUM_RN,
  localparam int IDX_W = idx_width(NUM_RN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RN-1:0] req,
  input  logic              adv,
  input  logic [IDX_W-1:0]  adv_idx,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [NUM_RN-1:0] gnt_onehot
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  // Scan from the pointer upward, wrapping; the first set request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_RN; i++) begin
      int k;
      k = int'(ptr_reg) + i;
      if (k >= NUM_RN) k = k - NUM_RN;
      if (!gnt_valid && req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RN; gi++) begin : g_onehot
    assign gnt_onehot[gi] = gnt_valid && (gnt_idx == IDX_W'(gi));
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (adv) begin
      ptr_next = (adv_idx == IDX_W'(NUM_RN - 1)) ? '0 : adv_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/chi_reset_sequencer.sv
// Staged cold-reset release for CHI SNs/RNs, plus per-RN warm resets granted
// round-robin while the system is READY.
module chi_reset_sequencer
  import chi_reset_seq_pkg::*;
#(
  parameter int NUM_RN   = DEF_NUM_RN,
  parameter int NUM_SN   = DEF_NUM_SN,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seq_start,
  input  logic [NUM_RN-1:0] rn_warm_req,
  output logic [NUM_RN-1:0] rn_warm_ack,
  output logic [NUM_RN-1:0] rn_resetn,
  output logic [NUM_SN-1:0] sn_resetn,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int IDX_W = idx_width(NUM_RN);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  seq_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  gnt_reg, gnt_next;
  logic [NUM_RN-1:0] rn_resetn_reg, rn_resetn_next;
  logic [NUM_SN-1:0] sn_resetn_reg, sn_resetn_next;
  logic [NUM_RN-1:0] ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              arb_valid;
  logic [IDX_W-1:0]  arb_idx;
  logic [NUM_RN-1:0] arb_onehot;
  logic              ptr_adv;
  logic [IDX_W-1:0]  idx_inc;
  logic [NUM_RN-1:0] idx_inc_dec;
  logic [NUM_RN-1:0] gnt_dec;

  assign idx_inc = idx_reg + IDX_W'(1);

  // Decoded views of the next RN to release and of the RN under warm reset.
  for (genvar gi = 0; gi < NUM_RN; gi++) begin : g_dec
    assign idx_inc_dec[gi] = (idx_inc == IDX_W'(gi));
    assign gnt_dec[gi]     = (gnt_reg == IDX_W'(gi));
  end

  chi_reset_rr_arb #(
    .NUM_RN (NUM_RN)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (rn_warm_req),
    .adv        (ptr_adv),
    .adv_idx    (gnt_reg),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx),
    .gnt_onehot (arb_onehot)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    idx_next       = idx_reg;
    gnt_next       = gnt_reg;
    rn_resetn_next = rn_resetn_reg;
    sn_resetn_next = sn_resetn_reg;
    ack_next       = '0;
    busy_next      = busy_reg;
    done_next      = done_reg;
    ptr_adv        = 1'b0;

    unique case (state_reg)
      ST_HOLD: begin
        rn_resetn_next = '0;
        sn_resetn_next = '0;
        if (cnt_reg == HOLD_LAST) begin
          sn_resetn_next = '1;
          cnt_next       = '0;
          state_next     = ST_GAP_SN;
        end
      end

      ST_GAP_SN: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next          = '0;
          idx_next          = '0;
          rn_resetn_next[0] = 1'b1;
          state_next        = ST_RN_REL;
        end
      end

      // Each RN gets a full gap after its release before the next one goes.
      ST_RN_REL: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          if (idx_reg == IDX_W'(NUM_RN - 1)) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_READY;
          end else begin
            idx_next       = idx_inc;
            rn_resetn_next = rn_resetn_reg | idx_inc_dec;
          end
        end
      end

      // A full re-sequence outranks any pending warm request.
      ST_READY: begin
        cnt_next = '0;
        if (seq_start) begin
          rn_resetn_next = '0;
          sn_resetn_next = '0;
          idx_next       = '0;
          busy_next      = 1'b1;
          done_next      = 1'b0;
          state_next     = ST_HOLD;
        end else if (arb_valid) begin
          gnt_next       = arb_idx;
          rn_resetn_next = rn_resetn_reg & ~arb_onehot;
          busy_next      = 1'b1;
          done_next      = 1'b0;
          state_next     = ST_WARM;
        end
      end

      ST_WARM: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next       = '0;
          rn_resetn_next = rn_resetn_reg | gnt_dec;
          ack_next       = gnt_dec;
          ptr_adv        = 1'b1;
          busy_next      = 1'b0;
          done_next      = 1'b1;
          state_next     = ST_READY;
        end
      end

      default: begin
        cnt_next       = '0;
        rn_resetn_next = '0;
        sn_resetn_next = '0;
        busy_next      = 1'b1;
        done_next      = 1'b0;
        state_next     = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HOLD;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      gnt_reg       <= '0;
      rn_resetn_reg <= '0;
      sn_resetn_reg <= '0;
      ack_reg       <= '0;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      gnt_reg       <= gnt_next;
      rn_resetn_reg <= rn_resetn_next;
      sn_resetn_reg <= sn_resetn_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign rn_warm_ack = ack_reg;
  assign rn_resetn   = rn_resetn_reg;
  assign sn_resetn   = sn_resetn_reg;
  assign seq_busy    = busy_reg;
  assign seq_done    = done_reg;

endmodule

// File: tb/tb_chi_reset_sequencer.sv
// Directed bench for chi_reset_sequencer: power-on, warm resets, collisions and
// mid-sequence reset, with hand-computed cycle expectations.
module tb_chi_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       seq_start;
  logic [3:0] rn_warm_req;
  logic [3:0] rn_warm_ack;
  logic [3:0] rn_resetn;
  logic [1:0] sn_resetn;
  logic       seq_busy;
  logic       seq_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cur      = 0;
  logic [3:0] acc_ack  = '0;

  chi_reset_sequencer #(
    .NUM_RN   (4),
    .NUM_SN   (2),
    .HOLD_CYC (16),
    .GAP_CYC  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seq_start   (seq_start),
    .rn_warm_req (rn_warm_req),
    .rn_warm_ack (rn_warm_ack),
    .rn_resetn   (rn_resetn),
    .sn_resetn   (sn_resetn),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cur, obs, exp);
    end
  endtask

  // Advance to mid-cycle c (negedge), collecting any ack pulses on the way.
  task automatic to_cycle(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
      acc_ack = acc_ack | rn_warm_ack;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rn"},   32'(rn_resetn),   32'h0);
    chk({tag, "_sn"},   32'(sn_resetn),   32'h0);
    chk({tag, "_ack"},  32'(rn_warm_ack), 32'h0);
    chk({tag, "_busy"}, 32'(seq_busy),    32'h1);
    chk({tag, "_done"}, 32'(seq_done),    32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    seq_start   = 1'b0;
    rn_warm_req = 4'b0000;

    // Power-on
    repeat (3) @(negedge clk);
    chk_reset_vals("por_in_rst");
    rst = 1'b0;
    cur = 0;
    to_cycle(15); chk("por_sn_15", 32'(sn_resetn), 32'h0);
    to_cycle(16); chk("por_sn_16", 32'(sn_resetn), 32'h3);
                  chk("por_rn_16", 32'(rn_resetn), 32'h0);
    to_cycle(19); chk("por_rn_19", 32'(rn_resetn), 32'h0);
    to_cycle(20); chk("por_rn_20", 32'(rn_resetn), 32'h1);
    to_cycle(24); chk("por_rn_24", 32'(rn_resetn), 32'h3);
    to_cycle(28); chk("por_rn_28", 32'(rn_resetn), 32'h7);
    to_cycle(31); chk("por_rn_31", 32'(rn_resetn), 32'h7);
    to_cycle(32); chk("por_rn_32", 32'(rn_resetn), 32'hf);
    to_cycle(35); chk("por_done_35", 32'(seq_done), 32'h0);
                  chk("por_busy_35", 32'(seq_busy), 32'h1);
    to_cycle(36); chk("por_done_36", 32'(seq_done), 32'h1);
                  chk("por_busy_36", 32'(seq_busy), 32'h0);

    // Single warm reset on RN2
    rn_warm_req = 4'b0100;
    to_cycle(37); chk("w1_rn_37", 32'(rn_resetn), 32'hb);
                  chk("w1_busy_37", 32'(seq_busy), 32'h1);
                  chk("w1_done_37", 32'(seq_done), 32'h0);
    to_cycle(52); chk("w1_rn_52", 32'(rn_resetn), 32'hb);
                  chk("w1_sn_52", 32'(sn_resetn), 32'h3);
                  chk("w1_ack_52", 32'(rn_warm_ack), 32'h0);
    to_cycle(53); chk("w1_ack_53", 32'(rn_warm_ack), 32'h4);
                  chk("w1_rn_53", 32'(rn_resetn), 32'hf);
                  chk("w1_done_53", 32'(seq_done), 32'h1);
    rn_warm_req = 4'b0000;
    to_cycle(54); chk("w1_ack_54", 32'(rn_warm_ack), 32'h0);
                  chk("w1_done_54", 32'(seq_done), 32'h1);

    // seq_start collides with a warm request in READY
    seq_start   = 1'b1;
    rn_warm_req = 4'b0001;
    to_cycle(55);
    seq_start   = 1'b0;
    rn_warm_req = 4'b0000;
    cur = 0;
    acc_ack = '0;
    chk_reset_vals("col_c0");
    to_cycle(15); chk("col_sn_15", 32'(sn_resetn), 32'h0);
    to_cycle(16); chk("col_sn_16", 32'(sn_resetn), 32'h3);
    to_cycle(20); chk("col_rn_20", 32'(rn_resetn), 32'h1);
    to_cycle(32); chk("col_rn_32", 32'(rn_resetn), 32'hf);
    to_cycle(35); chk("col_done_35", 32'(seq_done), 32'h0);
    to_cycle(36); chk("col_done_36", 32'(seq_done), 32'h1);
                  chk("col_no_ack", 32'(acc_ack), 32'h0);

    // Reset, then pulse rst again at cycle 26 of the new sequence
    rst = 1'b1;
    to_cycle(37);
    rst = 1'b0;
    cur = 0;
    chk_reset_vals("mid_c0");
    to_cycle(26); chk("mid_rn_26", 32'(rn_resetn), 32'h3);
    rst = 1'b1;
    to_cycle(27);
    chk_reset_vals("mid_after");
    rst = 1'b0;
    cur = 0;
    to_cycle(16); chk("mid_sn_16", 32'(sn_resetn), 32'h3);
    to_cycle(19); chk("mid_rn_19", 32'(rn_resetn), 32'h0);
    to_cycle(20); chk("mid_rn_20", 32'(rn_resetn), 32'h1);
    to_cycle(28); chk("mid_rn_28", 32'(rn_resetn), 32'h7);
    to_cycle(32); chk("mid_rn_32", 32'(rn_resetn), 32'hf);
    to_cycle(35); chk("mid_done_35", 32'(seq_done), 32'h0);
    to_cycle(36); chk("mid_done_36", 32'(seq_done), 32'h1);

    // Three warm requests from pointer 0; each drops on its ack
    rn_warm_req = 4'b1011;
    to_cycle(45); chk("mw_rn_45", 32'(rn_resetn), 32'he);
    to_cycle(52); chk("mw_ack_52", 32'(rn_warm_ack), 32'h0);
    to_cycle(53); chk("mw_ack0_53", 32'(rn_warm_ack), 32'h1);
    rn_warm_req = 4'b1010;
    to_cycle(60); chk("mw_rn_60", 32'(rn_resetn), 32'hd);
    to_cycle(69); chk("mw_ack_69", 32'(rn_warm_ack), 32'h0);
    to_cycle(70); chk("mw_ack1_70", 32'(rn_warm_ack), 32'h2);
    rn_warm_req = 4'b1000;
    to_cycle(80); chk("mw_rn_80", 32'(rn_resetn), 32'h7);
    to_cycle(86); chk("mw_ack_86", 32'(rn_warm_ack), 32'h0);
    to_cycle(87); chk("mw_ack3_87", 32'(rn_warm_ack), 32'h8);
                  chk("mw_rn_87", 32'(rn_resetn), 32'hf);
    rn_warm_req = 4'b0000;

    // seq_start during a warm reset of RN1 is dropped
    to_cycle(88); chk("sw_done_88", 32'(seq_done), 32'h1);
    rn_warm_req = 4'b0010;
    to_cycle(95);
    seq_start = 1'b1;
    to_cycle(96);
    seq_start = 1'b0;
    chk("sw_rn_96", 32'(rn_resetn), 32'hd);
    chk("sw_sn_96", 32'(sn_resetn), 32'h3);
    to_cycle(105); chk("sw_ack_105", 32'(rn_warm_ack), 32'h2);
                   chk("sw_done_105", 32'(seq_done), 32'h1);
    rn_warm_req = 4'b0000;
    to_cycle(106); chk("sw_rn_106", 32'(rn_resetn), 32'hf);
                   chk("sw_sn_106", 32'(sn_resetn), 32'h3);
                   chk("sw_busy_106", 32'(seq_busy), 32'h0);
                   chk("sw_done_106", 32'(seq_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
